// File: rtl/tsb_pkg.sv
// Shared constants and elaboration-time helpers for the tsb_rr_bus arbiter slice.
package tsb_pkg;

   localparam int ERRCNT_W = 16;

   // Index width for a vector of `value` entries; never narrower than 1 bit.
   function automatic int clog2(input int value);
      for (int w = 1; w < 32; w++) begin
         if ((1 << w) >= value) return w;
      end
      return 32;
   endfunction

endpackage

// File: rtl/tsb_rr_bus_if.sv
// Bundled writer-side and bus-side signals of tsb_rr_bus (tri-state bus replacement).
interface tsb_rr_bus_if import tsb_pkg::*; #(
   parameter int WIDTH    = 130,
   parameter int NWRITERS = 4
);

   logic [NWRITERS*WIDTH-1:0] io_in;
   logic [NWRITERS-1:0]       io_en;
   logic [NWRITERS-1:0]       io_lock;
   logic [WIDTH-1:0]          io_out;
   logic                      io_valid;
   logic [NWRITERS-1:0]       io_grant;
   logic                      io_contention;
   logic [ERRCNT_W-1:0]       io_err_cnt;

   modport master (
      output io_in, io_en, io_lock,
      input  io_out, io_valid, io_grant, io_contention, io_err_cnt
   );

   modport slave (
      input  io_in, io_en, io_lock,
      output io_out, io_valid, io_grant, io_contention, io_err_cnt
   );

endinterface

// File: rtl/tsb_rr_pick.sv
// Combinational rotate-priority picker: first set req bit at or above ptr, wrapping to 0.
module tsb_rr_pick import tsb_pkg::*; #(
   parameter int N  = 4,
   parameter int PW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic          found
);

   int pos;

   always_comb begin
      grant = '0;
      found = 1'b0;
      pos   = 0;
      for (int i = 0; i < N; i++) begin
         pos = int'(ptr) + i;
         if (pos >= N) pos = pos - N;
         // Constant j keeps every select static; only the matching position can fire.
         for (int j = 0; j < N; j++) begin
            if (!found && (pos == j) && req[j]) begin
               grant[j] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/tsb_rr_bus.sv
// Round-robin multi-writer bus with owner lock and bus-keeper output.
// Optional saturating contention counter enabled by defining TSB_ERRCNT_EN.
module tsb_rr_bus import tsb_pkg::*; #(
   parameter int WIDTH    = 130,
   parameter int NWRITERS = 4,
   parameter int LOCK_MAX = 8
) (
   input logic         clk,
   input logic         reset,
   tsb_rr_bus_if.slave bus
);

   localparam int             PW       = clog2(NWRITERS);
   localparam int             LCW      = 8;
   localparam logic [LCW-1:0] LOCK_CAP = LCW'(LOCK_MAX);

   logic [PW-1:0]       ptr_p1;
   logic [LCW-1:0]      lock_cnt_p1;
   logic [WIDTH-1:0]    out_p1;
   logic                vld_p1;
   logic [NWRITERS-1:0] grant_p1;
   logic                cont_p1;

   logic [NWRITERS-1:0] rr_grant;
   logic                rr_found;
   logic                lock_hit;
   logic [NWRITERS-1:0] win_oh;
   logic [WIDTH-1:0]    win_data;
   logic [PW-1:0]       ptr_nxt;
   logic                contention;
   logic                seen;

   tsb_rr_pick #(
      .N  (NWRITERS),
      .PW (PW)
   ) u_pick (
      .req   (bus.io_en),
      .ptr   (ptr_p1),
      .grant (rr_grant),
      .found (rr_found)
   );

   // Stage p0: arbitration on the sampled inputs.
   always_comb begin
      // grant_p1 is the last owner's one-hot; it is zero whenever the bus went idle.
      lock_hit   = vld_p1 && (|(grant_p1 & bus.io_en & bus.io_lock)) &&
                   (lock_cnt_p1 < LOCK_CAP);
      win_oh     = lock_hit ? grant_p1 : rr_grant;
      win_data   = '0;
      ptr_nxt    = ptr_p1;
      contention = 1'b0;
      seen       = 1'b0;
      for (int k = 0; k < NWRITERS; k++) begin
         if (win_oh[k]) begin
            win_data = bus.io_in[k*WIDTH +: WIDTH];
            ptr_nxt  = PW'((k + 1) % NWRITERS);
         end
         if (bus.io_en[k]) begin
            if (seen) contention = 1'b1;
            seen = 1'b1;
         end
      end
   end

   // Stage p1: registered bus state and arbitration history.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_p1      <= '0;
         vld_p1      <= 1'b0;
         grant_p1    <= '0;
         cont_p1     <= 1'b0;
         ptr_p1      <= '0;
         lock_cnt_p1 <= '0;
      end else begin
         cont_p1 <= contention;
         if (rr_found) begin
            out_p1      <= win_data;
            vld_p1      <= 1'b1;
            grant_p1    <= win_oh;
            ptr_p1      <= ptr_nxt;
            lock_cnt_p1 <= lock_hit ? (lock_cnt_p1 + LCW'(1)) : '0;
         end else begin
            vld_p1      <= 1'b0;
            grant_p1    <= '0;
            lock_cnt_p1 <= '0;
         end
      end
   end

`ifdef TSB_ERRCNT_EN
   logic [ERRCNT_W-1:0] err_cnt_p1;

   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt_p1 <= '0;
      end else if (contention && (err_cnt_p1 != '1)) begin
         err_cnt_p1 <= err_cnt_p1 + ERRCNT_W'(1);
      end
   end

   assign bus.io_err_cnt = err_cnt_p1;
`else
   assign bus.io_err_cnt = '0;
`endif

   assign bus.io_out        = out_p1;
   assign bus.io_valid      = vld_p1;
   assign bus.io_grant      = grant_p1;
   assign bus.io_contention = cont_p1;

endmodule
